semiring_systolic_array: RTL and testbench
==========================================

SEMIRING_SYSTOLIC_ARRAY -- requirements
Module: semiring_systolic_array

Interface
REQ-001 Parameter: N, 4, array dimension (N x N PEs, N>=2).
REQ-002 Parameter: W, 8, element and accumulator width in bits (W>=2).
REQ-003 Parameter: KMAX, 16, maximum inner dimension; KW = $clog2(KMAX+1).
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: ena  in  1  global clock enable; low freezes all state and outputs.
REQ-007 Port: start  in  1  begin job; sampled only in IDLE.
REQ-008 Port: mode  in  2  semiring select, latched on start: 0 OR/AND, 1 add/mul mod 2^W, 2 saturating add/mul, 3 tropical min/plus.
REQ-009 Port: k_len  in  KW  inner dimension, latched on start; 0 treated as 1, values >KMAX clamped to KMAX.
REQ-010 Port: in_valid  in  1  A column / B row beat valid.
REQ-011 Port: in_ready  out  1  beat accepted when in_valid & in_ready.
REQ-012 Port: a_col  in  N*W  A[0..N-1][k], element i at bits [i*W +: W].
REQ-013 Port: b_row  in  N*W  B[k][0..N-1], element j at bits [j*W +: W].
REQ-014 Port: out_valid  out  1  result row valid.
REQ-015 Port: out_ready  in  1  result row consumed when out_valid & out_ready.
REQ-016 Port: out_row  out  N*W  C[r][0..N-1], element j at [j*W +: W].
REQ-017 Port: out_last  out  1  high with out_valid on row N-1.
REQ-018 Port: busy  out  1  high in any state except IDLE.

Function
REQ-019 FSM states IDLE, FEED, DRAIN, OUT; all transitions require ena=1.
REQ-020 IDLE->FEED on start; accumulators set to semiring zero (0; all-ones for mode 3); start in other states ignored.
REQ-021 FEED: in_ready=1; after k_len accepted beats -> DRAIN; beat counter counts only accepted beats.
REQ-022 Array advances every enabled cycle in FEED/DRAIN; non-accepted FEED cycles inject annihilator (0; all-ones for mode 3) into both edges, leaving results unchanged.
REQ-023 Row i of A delayed i cycles, column j of B delayed j cycles by internal skew registers; PE(i,j) forwards a right, b down, one cycle each.
REQ-024 DRAIN lasts exactly 2N-1 cycles, then -> OUT with r=0.
REQ-025 PE update: mode 0 acc|=a&b (bitwise); mode 1 acc=(acc+a*b) mod 2^W; mode 2 acc=min(acc+min(a*b,2^W-1),2^W-1); mode 3 acc=min(acc, min(a+b,2^W-1)).
REQ-026 OUT: out_valid=1, out_row=C[r]; r advances on handshake; out_row/out_last stable while out_ready=0; handshake with out_last -> IDLE.
REQ-027 in_ready=0 and out_valid=0 outside FEED and OUT respectively.

Reset
REQ-028 rst_n low at any time (including mid-FEED/OUT): state IDLE, counters 0, accumulators and skew/PE registers 0, in_ready=0, out_valid=0, out_last=0, busy=0, out_row=0.
REQ-029 First start after reset release behaves identically to a start after a completed job.

Configuration
REQ-030 Macro SEMIRING_TROPICAL_EN defined: mode 3 per REQ-025.
REQ-031 Macro undefined: no tropical/min logic synthesised; mode 3 behaves exactly as mode 1, zero/annihilator 0.

Structure
REQ-032 Package semiring_pkg holds mode enum (SR_BOOL, SR_MODMUL, SR_SAT, SR_TROP), FSM state enum, and zero/annihilator functions of (mode, W).
REQ-033 Single sub-module semiring_pe (one PE: a/b forwarding registers, accumulator, mode ALU), instantiated N x N via generate.

Verification (N=4, W=8)
REQ-034 Mode 1, A=identity, B[k][j]=4k+j+1, k_len=4 -> rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, out_last on row 3.
REQ-035 k_len=1, all a=16, b=16: mode 1 -> all C=0; mode 2 -> all C=255; mode 0 -> all C=16.
REQ-036 Mode 3 (macro on), k_len=2, a=(10,3) all rows, b=(1,20) all cols -> all C=11; a=200,b=100,k_len=1 -> 255.
REQ-037 Random in_valid gaps and out_ready low 5 cycles mid-OUT -> results equal gap-free run; out_row stable while stalled.
REQ-038 rst_n low during FEED beat 2 -> busy=0, in_ready=0 immediately; fresh job then matches REQ-034.
REQ-039 Macro off, REQ-036 stimulus -> results equal mode 1 (C=10*1+3*20=70).

Source files
------------

// File: rtl/semiring_pkg.sv
// Shared types and helpers for the semiring systolic array.
// SEMIRING_TROPICAL_EN enables the tropical min/plus semiring (mode 3).
package semiring_pkg;

  typedef enum logic [1:0] {
    SR_BOOL   = 2'd0,
    SR_MODMUL = 2'd1,
    SR_SAT    = 2'd2,
    SR_TROP   = 2'd3
  } sr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } sr_state_e;

  localparam int unsigned SR_MAX_W = 64;

  // Without the tropical build, mode 3 folds onto plain modular add/mul.
  function automatic sr_mode_e sr_effective_mode(input sr_mode_e mode);
`ifdef SEMIRING_TROPICAL_EN
    return mode;
`else
    return (mode == SR_TROP) ? SR_MODMUL : mode;
`endif
  endfunction

  // Additive identity: all-ones for min/plus, zero otherwise.
  function automatic logic [SR_MAX_W-1:0] sr_zero(input sr_mode_e mode, input int unsigned w);
    logic [SR_MAX_W-1:0] v;
    v = '0;
    if (sr_effective_mode(mode) == SR_TROP) begin
      for (int unsigned i = 0; i < SR_MAX_W; i++) v[i] = (i < w);
    end
    return v;
  endfunction

  // Multiplicative annihilator; coincides with the additive identity here.
  function automatic logic [SR_MAX_W-1:0] sr_annihilator(input sr_mode_e mode, input int unsigned w);
    return sr_zero(mode, w);
  endfunction

endpackage

// File: rtl/semiring_pe.sv
// One processing element: forwards a right and b down, folds a (x) b into acc.
// The tropical ALU exists only when SEMIRING_TROPICAL_EN is defined.
module semiring_pe
  import semiring_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         adv,
  input  sr_mode_e     mode,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic [W-1:0] acc
);

  logic [W-1:0]   a_q, b_q, acc_q, acc_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_sat;
  logic [W:0]     sat_sum;

  assign prod     = {{W{1'b0}}, a_in} * {{W{1'b0}}, b_in};
  assign prod_sat = (|prod[2*W-1:W]) ? '1 : prod[W-1:0];
  assign sat_sum  = {1'b0, acc_q} + {1'b0, prod_sat};

`ifdef SEMIRING_TROPICAL_EN
  logic [W:0]   trop_sum;
  logic [W-1:0] trop_sat;
  assign trop_sum = {1'b0, a_in} + {1'b0, b_in};
  assign trop_sat = trop_sum[W] ? '1 : trop_sum[W-1:0];
`endif

  // NOTE: acc_next gets a value on every path (default first), so no latch is inferred.
  always_comb begin
    acc_next = acc_q + prod[W-1:0];
    case (mode)
      SR_BOOL: acc_next = acc_q | (a_in & b_in);
      SR_SAT:  acc_next = sat_sum[W] ? '1 : sat_sum[W-1:0];
`ifdef SEMIRING_TROPICAL_EN
      SR_TROP: acc_next = (trop_sat < acc_q) ? trop_sat : acc_q;
`endif
      default: acc_next = acc_q + prod[W-1:0];
    endcase
  end

  // NOTE: state uses non-blocking assignments so all PEs sample the old neighbour values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr) begin
      a_q   <= clr_val;
      b_q   <= clr_val;
      acc_q <= clr_val;
    end else if (adv) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_next;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/semiring_systolic_array.sv
// N x N output-stationary systolic array over a selectable semiring.
// SEMIRING_TROPICAL_EN enables mode 3 (min/plus); otherwise mode 3 acts as mode 1.
module semiring_systolic_array
  import semiring_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int KMAX = 16,
  localparam int KW  = $clog2(KMAX + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [KW-1:0]  k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_col,
  input  logic [N*W-1:0] b_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_row,
  output logic           out_last,
  output logic           busy
);

  localparam int DW = $clog2(2 * N);
  localparam int RW = $clog2(N);

  sr_state_e     state;
  sr_mode_e      mode_q, mode_in;
  logic [KW-1:0] k_q, k_eff, beat_cnt;
  logic [DW-1:0] drain_cnt;
  logic [RW-1:0] row;
  logic          clr, adv, accept;
  logic [W-1:0]  clr_val, ann;

  assign mode_in = sr_effective_mode(sr_mode_e'(mode));
  assign clr     = ena && (state == ST_IDLE) && start;
  assign adv     = ena && ((state == ST_FEED) || (state == ST_DRAIN));
  assign accept  = ena && in_valid && in_ready;
  assign clr_val = W'(sr_zero(mode_in, W));
  assign ann     = W'(sr_annihilator(mode_q, W));

  always_comb begin
    k_eff = k_len;
    if (k_len == '0) k_eff = KW'(1);
    else if (k_len > KW'(KMAX)) k_eff = KW'(KMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= SR_BOOL;
      k_q       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row       <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_FEED;
          mode_q   <= mode_in;
          k_q      <= k_eff;
          beat_cnt <= '0;
        end
        ST_FEED: if (in_valid) begin
          if (beat_cnt == k_q - KW'(1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + KW'(1);
          end
        end
        ST_DRAIN: begin
          // The last beat needs 2N-2 further hops to reach the far corner PE.
          if (drain_cnt == DW'(2 * N - 2)) begin
            state <= ST_OUT;
            row   <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_OUT: if (out_ready) begin
          if (row == RW'(N - 1)) state <= ST_IDLE;
          else row <= row + RW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_FEED);
  assign out_valid = (state == ST_OUT);
  assign out_last  = out_valid && (row == RW'(N - 1));
  assign busy      = (state != ST_IDLE);

  // Edge busses: a_bus[i][j] enters PE(i,j) from the left, b_bus[i][j] from above.
  logic [W-1:0] a_bus [N][N+1];
  logic [W-1:0] b_bus [N+1][N];
  logic [W-1:0] acc   [N][N];
  logic [W-1:0] a_inj [N];
  logic [W-1:0] b_inj [N];

  // Idle feed cycles inject the annihilator so the accumulators are untouched.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = accept ? a_col[i*W +: W] : ann;
      b_inj[i] = accept ? b_row[i*W +: W] : ann;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_bus[gi][0] = a_inj[gi];
      assign b_bus[0][gi] = b_inj[gi];
    end else begin : g_pipe
      logic [W-1:0] a_pipe [gi];
      logic [W-1:0] b_pipe [gi];
      // NOTE: the skew pipes are small register chains, not RAM, so they reset like any flop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < gi; d++) begin
            a_pipe[d] <= '0;
            b_pipe[d] <= '0;
          end
        end else if (clr) begin
          for (int d = 0; d < gi; d++) begin
            a_pipe[d] <= clr_val;
            b_pipe[d] <= clr_val;
          end
        end else if (adv) begin
          a_pipe[0] <= a_inj[gi];
          b_pipe[0] <= b_inj[gi];
          for (int d = 1; d < gi; d++) begin
            a_pipe[d] <= a_pipe[d-1];
            b_pipe[d] <= b_pipe[d-1];
          end
        end
      end
      assign a_bus[gi][0] = a_pipe[gi-1];
      assign b_bus[0][gi] = b_pipe[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      semiring_pe #(.W(W)) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .adv     (adv),
        .mode    (mode_q),
        .clr_val (clr_val),
        .a_in    (a_bus[gi][gj]),
        .b_in    (b_bus[gi][gj]),
        .a_out   (a_bus[gi][gj+1]),
        .b_out   (b_bus[gi+1][gj]),
        .acc     (acc[gi][gj])
      );
    end
  end

  logic unused_edges;
  always_comb begin
    unused_edges = 1'b0;
    for (int i = 0; i < N; i++) unused_edges = unused_edges ^ (^a_bus[i][N]) ^ (^b_bus[N][i]);
  end

  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) out_row[j*W +: W] = acc[row][j];
    end
  end

endmodule

// File: tb/tb_semiring_systolic_array.sv
// Scoreboard bench for semiring_systolic_array (N=4, W=8); works with or without
// SEMIRING_TROPICAL_EN, picking the matching expected values for mode 3.
module tb_semiring_systolic_array;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int KW = 5;

  logic          clk = 1'b0;
  logic          rst_n, ena, start, in_valid, out_ready;
  logic [1:0]    mode;
  logic [KW-1:0] k_len;
  logic [N*W-1:0] a_col, b_row;
  logic          in_ready, out_valid, out_last, busy;
  logic [N*W-1:0] out_row;

  semiring_systolic_array #(.N(N), .W(W), .KMAX(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .mode      (mode),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] row;
    logic           last;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] am   [0:N-1][0:15];
  logic [7:0] bm   [0:15][0:N-1];
  logic [7:0] cexp [0:N-1][0:N-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output row is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_row", out_row, 64'hdead);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_row", out_row, e.row);
        check("out_last", out_last, e.last);
      end
    end
  end

  task automatic fill_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) am[i][k] = (i == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < N; j++) bm[k][j] = 8'(4 * k + j + 1);
    cexp = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd5, 8'd6, 8'd7, 8'd8},
             '{8'd9, 8'd10, 8'd11, 8'd12}, '{8'd13, 8'd14, 8'd15, 8'd16}};
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) am[i][k] = av;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < N; j++) bm[k][j] = bv;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cexp[i][j] = cv;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300 && busy; c++) @(posedge clk);
    #1;
    check("job_done_busy", busy, 0);
    check("scoreboard_empty", sb_q.size(), 0);
  endtask

  task automatic drive_beat(input int kk);
    for (int i = 0; i < N; i++) begin
      a_col[i*W +: W] = am[i][kk];
      b_row[i*W +: W] = bm[kk][i];
    end
    in_valid = 1'b1;
    check("in_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [1:0] m, input int kb, input bit gaps, input bit stall);
    for (int r = 0; r < N; r++) begin
      exp_t e;
      for (int j = 0; j < N; j++) e.row[j*W +: W] = cexp[r][j];
      e.last = (r == N - 1);
      sb_q.push_back(e);
    end
    out_ready = !stall;
    mode = m;
    k_len = KW'(kb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int kk = 0; kk < kb; kk++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0;
          a_col = $urandom;
          b_row = $urandom;
          @(posedge clk); #1;
        end
      end
      drive_beat(kk);
    end
    in_valid = 1'b0;
    if (stall) begin
      for (int c = 0; c < 100 && !out_valid; c++) begin
        @(posedge clk); #1;
      end
      check("out_valid_arrives", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      begin
        logic [N*W:0] snap;
        snap = {out_last, out_row};
        repeat (5) begin
          @(posedge clk); #1;
          check("stall_hold", {out_valid, out_last, out_row}, {1'b1, snap});
        end
      end
      out_ready = 1'b1;
    end
    wait_idle();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'd0; k_len = '0;
    in_valid = 1'b0; out_ready = 1'b1; a_col = '0; b_row = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_row", out_row, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity times B returns B.
    fill_identity();
    run_job(2'd1, 4, 1'b0, 1'b0);

    // Single beat of 16*16: wraps, saturates, or stays 16 under AND.
    fill_const(8'd16, 8'd16, 8'd0);
    run_job(2'd1, 1, 1'b0, 1'b0);
    fill_const(8'd16, 8'd16, 8'd255);
    run_job(2'd2, 1, 1'b0, 1'b0);
    fill_const(8'd16, 8'd16, 8'd16);
    run_job(2'd0, 1, 1'b0, 1'b0);

    // Mode 3: a=(10,3), b=(1,20).
    fill_const(8'd0, 8'd0, 8'd0);
    for (int i = 0; i < N; i++) begin
      am[i][0] = 8'd10;
      am[i][1] = 8'd3;
      bm[0][i] = 8'd1;
      bm[1][i] = 8'd20;
    end
`ifdef SEMIRING_TROPICAL_EN
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) cexp[i][j] = 8'd11;
    run_job(2'd3, 2, 1'b0, 1'b0);
    fill_const(8'd200, 8'd100, 8'd255);
    run_job(2'd3, 1, 1'b0, 1'b0);
`else
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) cexp[i][j] = 8'd70;
    run_job(2'd3, 2, 1'b0, 1'b0);
    fill_const(8'd200, 8'd100, 8'd32);
    run_job(2'd3, 1, 1'b0, 1'b0);
`endif

    // Gapped input and stalled output give the same identity result.
    fill_identity();
    run_job(2'd1, 4, 1'b1, 1'b1);
    run_job(2'd1, 4, 1'b1, 1'b0);

    // Reset during FEED beat 2, then a clean job.
    mode = 2'd1; k_len = KW'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_beat(0);
    drive_beat(1);
    for (int i = 0; i < N; i++) begin
      a_col[i*W +: W] = am[i][2];
      b_row[i*W +: W] = bm[2][i];
    end
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(2'd1, 4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
